// File: rtl/adder_arb_pkg.sv
// Shared constants and the round-robin pick helper for the adder arbiter.
package adder_arb_pkg;

    localparam int ADD_W   = 32;
    localparam int MAX_REQ = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Scans valid starting at ptr and wrapping at nreq; first asserted bit wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int                 nreq);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= nreq) j = j - nreq;
            if (k < nreq && !r.found && valid[j[3:0]]) begin
                r.found = 1'b1;
                r.idx   = j[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational rotate-priority encoder: picks the first valid requester at or after ptr.
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), 4'(ptr), NREQ);
        found = pick.found;
        idx   = IDW'(pick.idx);
    end

endmodule

// File: rtl/full_adder_32.sv
// 32-bit adder with carry-in and carry-out shared by all requesters.
module full_adder_32
    import adder_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (ADD_W+1)'(a) + (ADD_W+1)'(b) + (ADD_W+1)'(cin);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one full_adder_32 with multi-word carry chaining.
// Optional ADDER_ARB_OVF_EN adds a registered signed-overflow output rsp_ovf.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [ADD_W-1:0]      rsp_sum,
    output logic                  rsp_cout
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    localparam logic ST_FREE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    logic             state;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   ptr;
    logic             carry_q;

    logic [NREQ-1:0]  elig;
    logic [IDW-1:0]   arb_ptr;
    logic             found;
    logic [IDW-1:0]   gidx;
    logic             accept;
    logic [IDW-1:0]   next_ptr;

    logic [ADD_W-1:0] op_a_p0;
    logic [ADD_W-1:0] op_b_p0;
    logic             op_cin_p0;
    logic             op_chain_p0;
    logic [ADD_W-1:0] sum_p0;
    logic             cout_p0;

    logic             vld_p1;
    logic [IDW-1:0]   id_p1;
    logic [ADD_W-1:0] sum_p1;
    logic             cout_p1;

    // While locked, only the owner can win, and the search starts at it.
    always_comb begin
        elig    = req_valid;
        arb_ptr = ptr;
        if (state == ST_LOCK) begin
            elig    = req_valid & (NREQ'(1) << owner);
            arb_ptr = owner;
        end
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid (elig),
        .ptr   (arb_ptr),
        .found (found),
        .idx   (gidx)
    );

    assign accept    = found && (!vld_p1 || rsp_ready);
    assign req_ready = accept ? (NREQ'(1) << gidx) : '0;
    assign next_ptr  = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;

    // ---- p0: operand select and add ----
    assign op_a_p0     = req_a[ADD_W*gidx +: ADD_W];
    assign op_b_p0     = req_b[ADD_W*gidx +: ADD_W];
    assign op_cin_p0   = (state == ST_LOCK) ? carry_q : req_cin[gidx];
    assign op_chain_p0 = req_chain[gidx];

    full_adder_32 u_add (
        .a    (op_a_p0),
        .b    (op_b_p0),
        .cin  (op_cin_p0),
        .sum  (sum_p0),
        .cout (cout_p0)
    );

    // ---- p1: response register and lock state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            state   <= ST_FREE;
            owner   <= '0;
            carry_q <= 1'b0;
            ptr     <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            id_p1   <= gidx;
            sum_p1  <= sum_p0;
            cout_p1 <= cout_p0;
            carry_q <= cout_p0;
            ptr     <= next_ptr;
            state   <= op_chain_p0 ? ST_LOCK : ST_FREE;
            owner   <= gidx;
        end else if (rsp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_cout  = cout_p1;

`ifdef ADDER_ARB_OVF_EN
    logic signed [ADD_W-1:0] sa_p0;
    logic signed [ADD_W-1:0] sb_p0;
    logic signed [ADD_W-1:0] ss_p0;
    logic                    ovf_p0;
    logic                    ovf_p1;

    assign sa_p0  = signed'(op_a_p0);
    assign sb_p0  = signed'(op_b_p0);
    assign ss_p0  = signed'(sum_p0);
    assign ovf_p0 = ((sa_p0 < 0) == (sb_p0 < 0)) && ((ss_p0 < 0) != (sa_p0 < 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ovf_p1 <= 1'b0;
        else if (accept) ovf_p1 <= ovf_p0;
    end

    assign rsp_ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter (NREQ=4); define ADDER_ARB_OVF_EN to cover rsp_ovf.
module tb_adder_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_cout;
`ifdef ADDER_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_word(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic chain);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = cin;
        req_chain[i]      = chain;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id,
                             input logic [31:0] sum, input logic cout);
        check({tag, "_valid"}, 64'(rsp_valid), 64'(1'b1));
        check({tag, "_id"},    64'(rsp_id),    64'(id));
        check({tag, "_sum"},   64'(rsp_sum),   64'(sum));
        check({tag, "_cout"},  64'(rsp_cout),  64'(cout));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_sum",   64'(rsp_sum),   64'(0));
        check("rst_cout",  64'(rsp_cout),  64'(0));
        check("rst_id",    64'(rsp_id),    64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
`ifdef ADDER_ARB_OVF_EN
        check("rst_ovf",   64'(rsp_ovf),   64'(0));
`endif
        rst_n = 1'b1;

        // Fairness: every requester valid, expect 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NREQ; i++) set_word(i, 32'(i), 32'h10, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            @(negedge clk);
            check_rsp("rr_rsp", 2'(k % 4), 32'(k % 4) + 32'h10, 1'b0);
        end
        req_valid = '0;

        // Single request from requester 2.
        set_word(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1 check("single_ready", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        check_rsp("single", 2'd2, 32'h0000_0000, 1'b1);
`ifdef ADDER_ARB_OVF_EN
        check("single_ovf", 64'(rsp_ovf), 64'(0));
`endif

        // Chained 64-bit add by requester 1.
        set_word(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        req_valid = 4'b0010;
        #1 check("chain_lo_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        check_rsp("chain_lo", 2'd1, 32'h0000_0000, 1'b1);
        set_word(0, 32'h1, 32'h1, 1'b0, 1'b0);
        set_word(2, 32'h2, 32'h2, 1'b0, 1'b0);
        set_word(3, 32'h3, 32'h3, 1'b0, 1'b0);
        req_valid = 4'b1101;
        #1 check("chain_stall_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("chain_stall_drain", 64'(rsp_valid), 64'(0));
        set_word(1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        req_valid = 4'b1111;
        #1 check("chain_hi_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        check_rsp("chain_hi", 2'd1, 32'h0000_0001, 1'b0);

        // ptr must now be 2; then backpressure with two requests waiting.
        set_word(0, 32'd100, 32'd1, 1'b0, 1'b0);
        set_word(2, 32'd10,  32'd20, 1'b0, 1'b0);
        set_word(3, 32'd5,   32'd7, 1'b1, 1'b0);
        req_valid = 4'b1101;
        #1 check("ptr_after_chain", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        check_rsp("bp_first", 2'd2, 32'd30, 1'b0);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_ready", 64'(req_ready), 64'(0));
            check_rsp("bp_hold", 2'd2, 32'd30, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("bp_rel_ready3", 64'(req_ready), 64'(4'b1000));
        @(negedge clk);
        check_rsp("bp_b2b_3", 2'd3, 32'd13, 1'b0);
        #1 check("bp_rel_ready0", 64'(req_ready), 64'(4'b0001));
        @(negedge clk);
        check_rsp("bp_b2b_0", 2'd0, 32'd101, 1'b0);
        req_valid = '0;

        // Reset in the middle of a chain held by requester 1.
        set_word(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        req_valid = 4'b0010;
        #1 check("rchain_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        check_rsp("rchain_lo", 2'd1, 32'h0000_0000, 1'b1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1 check("rchain_rst_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_word(0, 32'd5, 32'd0, 1'b1, 1'b0);
        set_word(1, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 4'b0011;
        #1 check("rchain_unlocked", 64'(req_ready), 64'(4'b0001));
        @(negedge clk);
        check_rsp("rchain_own_cin", 2'd0, 32'd6, 1'b0);
        req_valid = '0;

`ifdef ADDER_ARB_OVF_EN
        set_word(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        check("ovf_flag", 64'(rsp_ovf), 64'(1));
        check("ovf_sum",  64'(rsp_sum), 64'(32'h8000_0000));
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin controller that shares one `full_adder_32` instance among `NREQ` requesters. Each requester uses a valid/ready handshake. Every accepted operation returns through a single registered response port tagged with the requester ID. A requester may lock the adder for multi-word (chained-carry) additions, in which the carry-out of each word feeds the carry-in of the next word.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  `NREQ`: per-requester request valid.
- `req_ready`  out  `NREQ`: per-requester accept; at most one bit set per cycle.
- `req_a`  in  `NREQ*32`: operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  `NREQ*32`: operand B, same packing as `req_a`.
- `req_cin`  in  `NREQ`: carry-in; ignored while the adder is locked to that requester.
- `req_chain`  in  `NREQ`: 1 means this word is not the last word of a multi-word add.
- `rsp_valid`  out  1: response register holds a result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  `$clog2(NREQ)`: index of the requester that owns the result.
- `rsp_sum`  out  32: `sum` from `full_adder_32`.
- `rsp_cout`  out  1: `cout` from `full_adder_32`.

## Operation
- Datapath:
  - The selected requester's a and b drive the adder directly.
  - The adder's cin is `req_cin[i]` when unlocked, and `carry_q` when locked.
  - On accept, `{sum, cout}` and the ID are registered into the response register.
- Can-accept condition: `!rsp_valid || rsp_ready`, meaning the output slot is empty or is being drained this cycle.
- Unlocked mode:
  - Round-robin arbitration among asserted `req_valid` bits.
  - The search starts at `ptr` and wraps from `NREQ-1` to 0.
  - The winner gets `req_ready` only when the can-accept condition holds.
  - On accept, `ptr` becomes winner+1 (mod `NREQ`).
- Lock entry: accepting a word with `req_chain=1` sets `lock=1` and `owner=i`, and stores the adder's cout in `carry_q`.
- Locked mode:
  - Only `owner` is eligible; all other requesters see `req_ready=0`.
  - Each accepted word uses `carry_q` as cin and updates `carry_q` with its own cout.
  - Accepting a word with `req_chain=0` clears `lock` and advances `ptr` to owner+1.
- A locked owner that deasserts `req_valid` keeps the lock indefinitely (no timeout). Other requesters stall.
- When no request is accepted, the response register holds its value until `rsp_ready` drains it, and `rsp_valid` then falls.
- Outputs after reset:
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `req_ready=0`.
  - Internal state: `lock=0`, `carry_q=0`, `ptr=0`.
- An assertion of `rst_n` mid-chain discards the lock and any pending response. The owner must restart its chain.

## Timing
- `req_ready` is combinational from `req_valid`, `lock`, `ptr`, `rsp_valid` and `rsp_ready`. It does not depend on `req_a` or `req_b`.
- Latency: a request accepted at edge N produces `rsp_valid=1` with its result after edge N.
- Throughput is one operation per cycle when `rsp_ready` is held high.
- A response handshake and a new accept in the same cycle both take effect at the same edge: the new result replaces the old one with no bubble.
- With `rsp_ready=0` and `rsp_valid=1`, all `req_ready` bits are 0 and the response outputs are stable.
- The critical path is the 32-bit ripple through `full_adder_32` plus the `NREQ`:1 operand mux.

## Configuration
- `ADDER_ARB_OVF_EN` defined:
  - Adds output port `rsp_ovf  out  1`, the registered signed overflow `(a[31]==b[31]) && (sum[31]!=a[31])` of the accepted word.
  - Resets to 0.
- `ADDER_ARB_OVF_EN` undefined: the port and its flop are absent. All other behaviour is identical.

## Structure
- Package `adder_arb_pkg`: constant `ADD_W=32`, and function `rr_pick(valid, ptr)` returning the winner index and a found flag.
- Sub-module `rr_arbiter` (parameter `NREQ`): a purely combinational rotate-priority encoder. The top level holds the FSM (lock and owner), `carry_q`, `ptr`, the response register and the `full_adder_32` instance.

## Test plan
- Single request:
  - Stimulus: requester 2 sends a=`32'h0000_0001`, b=`32'hFFFF_FFFF`, cin=0, chain=0.
  - Response: rsp_sum=`32'h0000_0000`, rsp_cout=1, rsp_id=2, one cycle after accept.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid with `rsp_ready=1` for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3.
- Chained 64-bit add:
  - Stimulus: requester 1 sends the low word a=`FFFF_FFFF`, b=`0000_0001` (chain=1), then the high word a=`0000_0000`, b=`0000_0000` (chain=0, req_cin=0).
  - Response: sums `0000_0000` then `0000_0001`; requesters 0, 2 and 3 see no grant between the two words; `ptr` is 2 afterwards.
- Backpressure:
  - Stimulus: `rsp_ready=0` for 5 cycles with two requesters valid.
  - Response: `rsp_*` stable and `req_ready` all 0; releasing `rsp_ready` gives back-to-back results.
- Reset mid-chain:
  - Stimulus: drop `rst_n` after the first chained word.
  - Response: `rsp_valid=0` and `lock` cleared; the next accept from requester 0 uses its own `req_cin`.
- Overflow (with `ADDER_ARB_OVF_EN`):
  - Stimulus: a=`7FFF_FFFF`, b=`0000_0001`.
  - Response: rsp_ovf=1, rsp_sum=`8000_0000`.
